// File: rtl/bk_sd_pkg.sv
// Shared types and constants for the backup-RAM SD sequencer.
package bk_sd_pkg;

  localparam int unsigned SECTORS_DEF = 128;
  localparam int unsigned LBA_W       = 32;

  typedef enum logic [1:0] {
    BK_IDLE,
    BK_REQ,
    BK_WAIT
  } bk_state_e;

  // Index of the final sector in a transfer window of the given size.
  function automatic logic [6:0] last_sector(input int unsigned sectors);
    logic [31:0] s;
    s = sectors - 32'd1;
    return s[6:0];
  endfunction

endpackage

// File: rtl/bk_edge_det.sv
// Registered rise/fall detector, one bit lane per input, synchronous active-high reset.
module bk_edge_det #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  logic [Width-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;
  assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/bk_sd_sequencer.sv
// Backup-RAM save/load sequencer over the hps_io SD sector handshake.
// Optional watchdog abort enabled by defining BK_SD_TIMEOUT_EN.
module bk_sd_sequencer
  import bk_sd_pkg::*;
#(
  parameter int unsigned SECTORS     = SECTORS_DEF,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic             clk_sys_i,
  input  logic             reset_i,
  input  logic             downloading_i,
  input  logic             img_mounted_i,
  input  logic             img_readonly_i,
  input  logic             img_size_nz_i,
  input  logic             load_req_i,
  input  logic             save_req_i,
  input  logic             autosave_en_i,
  input  logic             osd_status_i,
  input  logic             bram_change_i,
  input  logic             sd_ack_i,
  output logic [LBA_W-1:0] sd_lba_o,
  output logic             sd_rd_o,
  output logic             sd_wr_o,
  output logic             bk_ena_o,
  output logic             loading_o,
  output logic             busy_o,
  output logic             sav_pending_o,
  output logic             err_o
);

  localparam logic [6:0] LastLba = last_sector(SECTORS);

  bk_state_e  state_q, state_d;
  logic [6:0] lba_q, lba_d;
  logic       rd_q, rd_d, wr_q, wr_d;
  logic       loading_q, loading_d, busy_q, busy_d;
  // Not reset: these survive a core reset and only power up cleared.
  logic       bk_ena_q = 1'b0;
  logic       sav_pending_q = 1'b0;
  logic       bk_ena_d, sav_pending_d;

  logic       auto_term;
  logic [4:0] edge_rise, edge_fall;
  logic       ack_rise, ack_fall;
  logic       trig_auto, trig_load, trig_save, start_load, start, save_start;

  assign auto_term = sav_pending_q & osd_status_i & autosave_en_i;

  bk_edge_det #(
    .Width(5)
  ) u_edge (
    .clk_i (clk_sys_i),
    .rst_i (reset_i),
    .d_i   ({downloading_i, load_req_i, save_req_i, sd_ack_i, auto_term}),
    .rise_o(edge_rise),
    .fall_o(edge_fall)
  );

  assign ack_rise   = edge_rise[1];
  assign ack_fall   = edge_fall[1];
  assign trig_auto  = bk_ena_q & edge_fall[4] & img_size_nz_i;
  assign trig_load  = bk_ena_q & edge_rise[3];
  assign trig_save  = bk_ena_q & (edge_rise[2] | edge_rise[0]);
  assign start_load = trig_auto | trig_load;
  assign start      = start_load | trig_save;

`ifdef BK_SD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            timeout;

  // Any ack edge counts as progress and restarts the watchdog.
  assign timeout = (state_q != BK_IDLE) && !(ack_rise || ack_fall) &&
                   (cnt_q == CntW'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    loading_d  = loading_q;
    busy_d     = busy_q;
    save_start = 1'b0;
    unique case (state_q)
      BK_IDLE: begin
        if (start) begin
          state_d    = BK_REQ;
          lba_d      = '0;
          loading_d  = start_load;
          rd_d       = start_load;
          wr_d       = ~start_load;
          busy_d     = 1'b1;
          save_start = ~start_load;
        end
      end
      BK_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = BK_WAIT;
        end
      end
      BK_WAIT: begin
        if (ack_fall) begin
          if (lba_q == LastLba) begin
            state_d   = BK_IDLE;
            loading_d = 1'b0;
            busy_d    = 1'b0;
          end else begin
            lba_d   = lba_q + 7'd1;
            rd_d    = loading_q;
            wr_d    = ~loading_q;
            state_d = BK_REQ;
          end
        end
      end
      default: state_d = BK_IDLE;
    endcase
`ifdef BK_SD_TIMEOUT_EN
    if (timeout) begin
      state_d   = BK_IDLE;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      loading_d = 1'b0;
      busy_d    = 1'b0;
    end
`endif
  end

  always_comb begin
    bk_ena_d = bk_ena_q;
    if (edge_rise[4]) bk_ena_d = 1'b0;
    if (downloading_i && img_mounted_i && !img_readonly_i) bk_ena_d = 1'b1;

    sav_pending_d = sav_pending_q;
    if (save_start) sav_pending_d = 1'b0;
    if (bram_change_i && !osd_status_i) sav_pending_d = 1'b1;
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q   <= BK_IDLE;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lba_q         <= lba_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      loading_q     <= loading_d;
      busy_q        <= busy_d;
      bk_ena_q      <= bk_ena_d;
      sav_pending_q <= sav_pending_d;
    end
  end

`ifdef BK_SD_TIMEOUT_EN
  always_comb begin
    err_d = err_q;
    cnt_d = '0;
    if (state_q != BK_IDLE && !(ack_rise || ack_fall)) cnt_d = cnt_q + 1'b1;
    if (state_q == BK_IDLE && start) err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign err_o = 1'b0;
`endif

  assign sd_lba_o      = {{(LBA_W - 7){1'b0}}, lba_q};
  assign sd_rd_o       = rd_q;
  assign sd_wr_o       = wr_q;
  assign bk_ena_o      = bk_ena_q;
  assign loading_o     = loading_q;
  assign busy_o        = busy_q;
  assign sav_pending_o = sav_pending_q;

endmodule

// File: tb/tb_bk_sd_sequencer.sv
// Directed bench for bk_sd_sequencer with a queue of expected sector requests.
module tb_bk_sd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        downloading = 1'b0, img_mounted = 1'b0, img_readonly = 1'b0;
  logic        img_size_nz = 1'b0, load_req = 1'b0, save_req = 1'b0;
  logic        autosave_en = 1'b0, osd_status = 1'b0, bram_change = 1'b0, sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, loading, busy, sav_pending, err;

  typedef struct packed {
    logic        load;
    logic [31:0] lba;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bk_sd_sequencer #(
    .SECTORS    (128),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk_sys_i    (clk),
    .reset_i      (reset),
    .downloading_i(downloading),
    .img_mounted_i(img_mounted),
    .img_readonly_i(img_readonly),
    .img_size_nz_i(img_size_nz),
    .load_req_i   (load_req),
    .save_req_i   (save_req),
    .autosave_en_i(autosave_en),
    .osd_status_i (osd_status),
    .bram_change_i(bram_change),
    .sd_ack_i     (sd_ack),
    .sd_lba_o     (sd_lba),
    .sd_rd_o      (sd_rd),
    .sd_wr_o      (sd_wr),
    .bk_ena_o     (bk_ena),
    .loading_o    (loading),
    .busy_o       (busy),
    .sav_pending_o(sav_pending),
    .err_o        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfer(input logic load, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.load = load;
      e.lba  = 32'(i);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_bram();
    bram_change = 1'b1;
    tick();
    bram_change = 1'b0;
    tick();
  endtask

  // Acts as hps_io: answers n requests, comparing each against the queue head.
  task automatic serve(input int n, input bit stop_in_wait);
    exp_t e;
    int   waited;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      while (!(sd_rd || sd_wr) && waited < 50) begin
        tick();
        waited++;
      end
      check("req_seen", {31'd0, sd_rd | sd_wr}, 32'd1);
      if (!(sd_rd || sd_wr)) begin
        sb.delete();
        return;
      end
      e = sb.pop_front();
      check("lba", sd_lba, e.lba);
      check("rd", {31'd0, sd_rd}, {31'd0, e.load});
      check("wr", {31'd0, sd_wr}, {31'd0, ~e.load});
      check("loading_mid", {31'd0, loading}, {31'd0, e.load});
      sd_ack = 1'b1;
      tick();
      check("req_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
      if (stop_in_wait && k == n - 1) return;
      sd_ack = 1'b0;
      tick();
    end
    check("end_loading", {31'd0, loading}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_lba", sd_lba, 32'd0);
    check("rst_rd", {31'd0, sd_rd}, 32'd0);
    check("rst_wr", {31'd0, sd_wr}, 32'd0);
    check("rst_loading", {31'd0, loading}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_bk_ena", {31'd0, bk_ena}, 32'd0);
    check("rst_sav_pending", {31'd0, sav_pending}, 32'd0);

    // Auto-load after ROM download with a RW image
    downloading = 1'b1;
    tick();
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    check("mount_bk_ena", {31'd0, bk_ena}, 32'd1);
    img_size_nz = 1'b1;
    push_xfer(1'b1, 128);
    downloading = 1'b0;
    tick();
    check("auto_rd_first", {31'd0, sd_rd}, 32'd1);
    check("auto_loading", {31'd0, loading}, 32'd1);
    check("auto_busy", {31'd0, busy}, 32'd1);
    serve(128, 1'b0);

    // Manual save after a cartridge write with the OSD closed
    pulse_bram();
    check("save_pending_set", {31'd0, sav_pending}, 32'd1);
    push_xfer(1'b0, 128);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    check("save_busy", {31'd0, busy}, 32'd1);
    check("save_pending_clr", {31'd0, sav_pending}, 32'd0);
    check("save_wr_first", {31'd0, sd_wr}, 32'd1);
    serve(128, 1'b0);

    // Autosave on OSD open
    pulse_bram();
    check("auto_pending_set", {31'd0, sav_pending}, 32'd1);
    autosave_en = 1'b1;
    push_xfer(1'b0, 128);
    osd_status = 1'b1;
    tick();
    check("autosave_busy", {31'd0, busy}, 32'd1);
    check("autosave_wr", {31'd0, sd_wr}, 32'd1);
    serve(128, 1'b0);
    osd_status = 1'b0;
    tick();

    // Autosave disabled: OSD open must not start a save
    autosave_en = 1'b0;
    pulse_bram();
    check("noauto_pending", {31'd0, sav_pending}, 32'd1);
    osd_status = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("noauto_req", {30'd0, sd_rd, sd_wr}, 32'd0);
    end
    check("noauto_busy", {31'd0, busy}, 32'd0);
    osd_status = 1'b0;
    tick();

    // Read-only image: save disabled, manual load ignored
    img_size_nz = 1'b0;
    downloading = 1'b1;
    tick();
    img_mounted  = 1'b1;
    img_readonly = 1'b1;
    tick();
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    downloading  = 1'b0;
    tick();
    check("ro_bk_ena", {31'd0, bk_ena}, 32'd0);
    load_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ro_no_rd", {31'd0, sd_rd}, 32'd0);
    end
    load_req = 1'b0;
    tick();

    // Reset while waiting for ack fall at sector 5
    downloading = 1'b1;
    tick();
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    downloading = 1'b0;
    tick();
    check("rw_bk_ena", {31'd0, bk_ena}, 32'd1);
    push_xfer(1'b1, 6);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    serve(6, 1'b1);
    check("mid_lba5", sd_lba, 32'd5);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    sd_ack = 1'b0;
    check("midrst_rd", {31'd0, sd_rd}, 32'd0);
    check("midrst_loading", {31'd0, loading}, 32'd0);
    check("midrst_lba", sd_lba, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_bk_ena", {31'd0, bk_ena}, 32'd1);
    tick();

    // Simultaneous load and save requests: load has priority
    push_xfer(1'b1, 128);
    load_req = 1'b1;
    save_req = 1'b1;
    tick();
    load_req = 1'b0;
    save_req = 1'b0;
    check("prio_rd", {31'd0, sd_rd}, 32'd1);
    check("prio_wr", {31'd0, sd_wr}, 32'd0);
    check("prio_loading", {31'd0, loading}, 32'd1);
    serve(128, 1'b0);
    check("final_err", {31'd0, err}, 32'd0);

`ifdef BK_SD_TIMEOUT_EN
    // Watchdog abort with ack never rising
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("to_busy", {31'd0, busy}, 32'd1);
    repeat (99) tick();
    check("to_busy_hold", {31'd0, busy}, 32'd1);
    tick();
    check("to_abort_busy", {31'd0, busy}, 32'd0);
    check("to_abort_rd", {31'd0, sd_rd}, 32'd0);
    check("to_abort_loading", {31'd0, loading}, 32'd0);
    check("to_err", {31'd0, err}, 32'd1);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("to_err_clr", {31'd0, err}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bk_sd_sequencer.md
Name: bk_sd_sequencer

Overview:
- Sequences backup-RAM (cartridge SRAM/EEPROM) save and load transfers through the hps_io SD block interface.
- Steps sd_lba across a fixed sector window and drives the sd_rd/sd_wr/sd_ack handshake.
- Handles the automatic load after a ROM download, manual OSD load/save, and autosave when the OSD opens.
- Sits in emu between hps_io and system. The BRAM data path (sd_buff_*) is outside this block; the block supplies sd_lba[6:0] as the BRAM sector address.

Parameters:
- SECTORS, 128: number of 512-byte sectors per transfer; power of two, 2..128.
- TIMEOUT_CYC, 50000000: watchdog limit in clk_sys cycles; used only with BK_SD_TIMEOUT_EN.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- downloading  in  1  ROM download in progress (ioctl_download)
- img_mounted  in  1  save image mount strobe
- img_readonly  in  1  mounted image is read-only
- img_size_nz  in  1  mounted image size is non-zero
- load_req  in  1  OSD "Load Backup RAM" level
- save_req  in  1  OSD "Save Backup RAM" level
- autosave_en  in  1  autosave option
- osd_status  in  1  OSD open
- bram_change  in  1  pulse: cartridge wrote backup RAM
- sd_ack  in  1  hps_io sector acknowledge (level)
- sd_lba  out  32  sector address
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- bk_ena  out  1  save image usable
- loading  out  1  load transfer active; the top holds the core in reset while high
- busy  out  1  any transfer active
- sav_pending  out  1  unsaved backup-RAM changes exist
- err  out  1  sticky timeout flag; tied 0 without the macro

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is synchronous and active-high.
- Reset action: state=IDLE; sd_lba=0, sd_rd=0, sd_wr=0, loading=0, busy=0, err=0.
- Reset preserves bk_ena and sav_pending. Both power-up to 0.
- The top must not feed loading back into this block's reset.
- Registered edge detectors, all cleared by reset: downloading, load_req, save_req, sd_ack, and the autosave term (sav_pending & osd_status & autosave_en).
- bk_ena:
  - Cleared on the rising edge of downloading.
  - Set in any cycle with downloading & img_mounted & ~img_readonly.
  - The set wins if both occur in the same cycle.
- sav_pending:
  - Set when bram_change & ~osd_status.
  - Cleared in the first busy cycle of a save.
  - The set wins over the clear if both occur in the same cycle.
- FSM states:
  - IDLE.
  - REQ: request asserted, waiting for sd_ack rise.
  - WAIT: waiting for sd_ack fall.
- IDLE triggers, each requiring bk_ena. Priority when several fire in the same cycle: auto-load > manual load > save.
  - Auto-load: falling edge of downloading & img_size_nz.
  - Manual load: load_req rising edge.
  - Save: save_req rising edge or autosave-term rising edge.
- IDLE to REQ: next cycle sd_lba=0, loading=(trigger is a load), sd_rd=loading, sd_wr=~loading, busy=1.
- REQ:
  - On a registered sd_ack rising edge, clear sd_rd and sd_wr the same cycle and go to WAIT.
  - Exactly one of sd_rd/sd_wr is high throughout REQ.
- WAIT, on an sd_ack falling edge:
  - If sd_lba == SECTORS-1: go to IDLE; loading=0, busy=0.
  - Otherwise: sd_lba += 1, reassert the same request, go to REQ.
- Triggers arriving while busy are ignored, not queued.
- sd_ack already high at trigger: the rise is not seen until ack falls and rises again. This is intended.
- sd_lba[31:7] is always 0.
- Loading deasserts exactly one cycle after the final ack fall.

Optional Feature:
- Macro: BK_SD_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to REQ/WAIT and on each ack edge.
  - If it reaches TIMEOUT_CYC, the FSM aborts to IDLE: sd_rd=0, sd_wr=0, loading=0, busy=0, err=1.
  - err clears on the next accepted trigger or on reset.
- When undefined: no counter is built, err is constant 0, and a hang waits forever.

Decomposition:
- Package bk_sd_pkg: state enum (BK_IDLE, BK_REQ, BK_WAIT), SECTORS_DEF=128, LBA_W=32, and a helper function last_sector(SECTORS).
- One natural sub-module, bk_edge_det: parameterised-width rise/fall detector with synchronous reset, instanced for the five edge inputs.

Test Plan:
- Auto-load: mount RW image during download, img_size_nz=1, drop downloading.
  - Expect sd_rd first cycle after the fall and loading=1.
  - Expect 128 rd handshakes with sd_lba 0..127, each request dropped the cycle after the ack rise.
  - Expect loading=0 one cycle after the 128th ack fall.
- Manual save after bram_change with the OSD closed:
  - Expect sav_pending=1.
  - Pulse save_req: expect 128 sd_wr handshakes and sav_pending=0 on the first busy cycle.
- Autosave, autosave_en=1, sav_pending=1:
  - Raise osd_status: expect a save to start.
  - Repeat with autosave_en=0: expect no request.
- img_readonly=1 at mount, then pulse load_req: expect bk_ena=0 and sd_rd never asserted.
- Reset asserted while in WAIT at sd_lba=5: expect sd_rd=0, loading=0, sd_lba=0 the next cycle, with bk_ena still 1.
- Simultaneous load_req and save_req rising edges: expect a load (sd_rd). With BK_SD_TIMEOUT_EN, TIMEOUT_CYC=100 and sd_ack never rising: expect an abort at cycle 100 with err=1.
